// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian 32-bit words from a byte stream,
// writes them to instruction memory and releases the CPU once the XOR checksum matches.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // 17 bits so that a full 2^16-word memory still compares correctly
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] n_words;
  logic [7:0]  csum;
  logic [1:0]  byte_cnt;
  logic [23:0] word_p0;
  logic        accept;
  logic [15:0] n_hdr;
  logic        word_done;

  function automatic logic oversize(input logic [15:0] n);
    return {1'b0, n} > CAPACITY;
  endfunction

  assign rx_ready   = (state != S_DONE) && (state != S_ERROR);
  assign cpu_run    = (state == S_DONE);
  assign load_error = (state == S_ERROR);

  always_comb begin
    accept    = rx_valid && rx_ready;
    n_hdr     = {rx_data, n_words[7:0]};
    word_done = accept && (state == S_LOAD) && (byte_cnt == 2'd3);
    state_nxt = state;
    case (state)
      S_HDR0: if (accept) state_nxt = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if (oversize(n_hdr))        state_nxt = S_ERROR;
          else if (n_hdr == 16'd0)    state_nxt = S_CHECK;
          else                        state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (word_done && (words_loaded + 16'd1 == n_words)) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_HDR0;
    else        state <= state_nxt;
  end

  // Byte intake: header capture, checksum, word assembly and the registered write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_words      <= '0;
      csum         <= '0;
      byte_cnt     <= '0;
      word_p0      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_HDR0: begin
            n_words[7:0] <= rx_data;
            csum         <= csum ^ rx_data;
          end
          S_HDR1: begin
            n_words[15:8] <= rx_data;
            csum          <= csum ^ rx_data;
          end
          S_LOAD: begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
              imem_wdata   <= {rx_data, word_p0};
              words_loaded <= words_loaded + 16'd1;
            end else begin
              // earlier bytes slide down so the first byte ends up in bits 7:0
              word_p0 <= {rx_data, word_p0[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts writes, acceptance
// and final status; a per-cycle monitor compares the DUT against it.
module tb_imem_loader;
  localparam int AW = 10;

  logic          clock;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          load_error;
  logic [15:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int acc = 0;
  int exp_acc = 0;
  bit exp_done = 0;
  bit model_on = 0;
  int cyc = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int wcyc[$];
  logic [31:0] ea;
  logic [31:0] ed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Stream-level model: what a correct loader must write and how it must finish
  function automatic void build(input logic [7:0] s[$]);
    int n;
    logic [7:0] cs;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    n = int'({s[1], s[0]});
    if (n > (1 << AW)) begin
      exp_acc  = 2;
      exp_done = 0;
    end else begin
      cs = s[0] ^ s[1];
      for (int i = 0; i < n; i++) begin
        w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
        exp_addr.push_back(32'(i));
        exp_data.push_back(w);
        cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      end
      exp_acc  = 3 + 4 * n;
      exp_done = (s[2+4*n] == cs);
    end
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (model_on && reset) begin
      chk("run_err_exclusive", {31'd0, cpu_run && load_error}, 32'd0);
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, acc < exp_acc});
      if (imem_we) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          chk("we_addr", 32'(imem_addr), ea);
          chk("we_data", imem_wdata, ed);
          chk("words_after_we", 32'(words_loaded), ea + 32'd1);
          obs_addr.push_back(32'(imem_addr));
          obs_data.push_back(imem_wdata);
          wcyc.push_back(cyc);
        end
      end
      if (rx_valid && rx_ready) acc++;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    bit got;
    int n;
    got = 0;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!got && n < 50) begin
      @(negedge clock);
      got = rx_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!got) chk("handshake_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_stream(input logic [7:0] s[$], input int gapmax);
    for (int i = 0; i < s.size(); i++)
      send(s[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic start_test(input logic [7:0] s[$], input bit check_reset);
    model_on = 0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    if (check_reset) begin
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
      chk("rst_load_error", {31'd0, load_error}, 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
    end
    reset = 1'b1;
    acc = 0;
    obs_addr.delete();
    obs_data.delete();
    wcyc.delete();
    build(s);
    model_on = 1;
  endtask

  task automatic junk();
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (8) begin
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic final_check(input bit done, input int words);
    chk("final_cpu_run", {31'd0, cpu_run}, {31'd0, done});
    chk("final_load_error", {31'd0, load_error}, {31'd0, !done});
    chk("final_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("final_words", 32'(words_loaded), 32'(words));
    chk("final_writes_pending", 32'(exp_addr.size()), 32'd0);
    chk("final_accepted", 32'(acc), 32'(exp_acc));
    chk("model_done", {31'd0, exp_done}, {31'd0, done});
  endtask

  task automatic check_good_writes();
    chk("num_writes", 32'(obs_data.size()), 32'd2);
    if (obs_data.size() == 2) begin
      chk("w0_addr", obs_addr[0], 32'd0);
      chk("w0_data", obs_data[0], 32'h00500093);
      chk("w1_addr", obs_addr[1], 32'd1);
      chk("w1_data", obs_data[1], 32'h00100113);
    end
  endtask

  logic [7:0] good[$];
  logic [7:0] bad[$];
  logic [7:0] s[$];

  initial begin
    reset = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    good = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
    bad  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC2};

    // good image, one byte per cycle
    start_test(good, 1);
    chk("model_len_good", 32'(exp_acc), 32'd11);
    run_stream(good, 0);
    chk("good_cpu_run_next", {31'd0, cpu_run}, 32'd1);
    junk();
    final_check(1, 2);
    check_good_writes();
    if (wcyc.size() == 2) chk("we_spacing", 32'(wcyc[1] - wcyc[0]), 32'd4);
    else chk("we_spacing_count", 32'(wcyc.size()), 32'd2);

    // bad checksum
    start_test(bad, 0);
    run_stream(bad, 0);
    chk("bad_error_next", {31'd0, load_error}, 32'd1);
    chk("bad_cpu_run", {31'd0, cpu_run}, 32'd0);
    junk();
    final_check(0, 2);
    check_good_writes();

    // empty image
    s = '{8'h00, 8'h00, 8'h00};
    start_test(s, 0);
    run_stream(s, 0);
    chk("empty_cpu_run_next", {31'd0, cpu_run}, 32'd1);
    junk();
    final_check(1, 0);
    chk("empty_no_writes", 32'(obs_data.size()), 32'd0);

    // oversize header N=1025
    s = '{8'h01, 8'h04};
    start_test(s, 0);
    chk("model_len_oversize", 32'(exp_acc), 32'd2);
    run_stream(s, 0);
    chk("over_error_next", {31'd0, load_error}, 32'd1);
    junk();
    final_check(0, 0);
    chk("over_no_writes", 32'(obs_data.size()), 32'd0);

    // good image with idle gaps
    start_test(good, 0);
    run_stream(good, 5);
    junk();
    final_check(1, 2);
    check_good_writes();

    // asynchronous reset in the middle of the first word
    start_test(good, 0);
    s = '{8'h02, 8'h00, 8'h93, 8'h00};
    run_stream(s, 0);
    chk("midword_accepted", 32'(acc), 32'd4);
    chk("midword_no_writes", 32'(obs_data.size()), 32'd0);
    #2;
    model_on = 0;
    reset = 1'b0;
    #1;
    chk("mid_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("mid_imem_we", {31'd0, imem_we}, 32'd0);
    chk("mid_imem_addr", 32'(imem_addr), 32'd0);
    chk("mid_imem_wdata", imem_wdata, 32'd0);
    chk("mid_cpu_run", {31'd0, cpu_run}, 32'd0);
    chk("mid_load_error", {31'd0, load_error}, 32'd0);
    chk("mid_words", 32'(words_loaded), 32'd0);
    start_test(good, 0);
    run_stream(good, 0);
    junk();
    final_check(1, 2);
    check_good_writes();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits upstream of the `cpu` core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the instruction memory read by the fetch unit, and the block verifies a trailing XOR checksum. The CPU stays held in reset until a complete, checksum-correct image has been written; only then does `cpu_run` release it.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words.

- `clock`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `rx_valid`  in  1  upstream byte valid
- `rx_data`  in  8  upstream byte
- `rx_ready`  out  1  loader can accept a byte
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word
- `imem_addr`  out  ADDR_WIDTH  word address for the write
- `imem_wdata`  out  32  instruction word for the write
- `cpu_run`  out  1  1 = image valid, CPU released; drives the CPU reset (CPU reset = ~cpu_run)
- `load_error`  out  1  sticky error flag
- `words_loaded`  out  16  count of words written so far

## Operation
- A byte is accepted on a rising edge where `rx_valid && rx_ready`. Nothing else consumes input.
- Stream format:
  - HDR: 2 bytes, word count N, 16-bit little-endian.
  - PAYLOAD: 4N bytes, each word little-endian (first byte = bits 7:0).
  - CHK: 1 byte.
- Running checksum `csum` (8 bits) = XOR of every accepted header and payload byte. The CHK byte must equal `csum`.
- States and transitions:
  - HDR0: accept byte into N[7:0], then go to HDR1.
  - HDR1: accept byte into N[15:8], then evaluate N:
    - N > 2^ADDR_WIDTH: go to ERROR.
    - N == 0: go to CHECK.
    - otherwise: go to LOAD.
  - LOAD: a 2-bit byte counter shifts each byte into a word register.
    - On the 4th byte, issue a write at address = `words_loaded`, then increment `words_loaded`.
    - When `words_loaded` reaches N, go to CHECK.
  - CHECK: accept one byte.
    - Equal to `csum`: go to DONE.
    - Otherwise: go to ERROR.
  - DONE: `cpu_run`=1. Terminal until `reset`.
  - ERROR: `load_error`=1, `cpu_run`=0. Terminal until `reset`.
- `rx_ready` = 1 in HDR0, HDR1, LOAD and CHECK; 0 in DONE and ERROR. Bytes offered in DONE or ERROR are never accepted.
- Address arithmetic: `imem_addr` = `words_loaded[ADDR_WIDTH-1:0]`. It never wraps, because oversize N is rejected at the header.
- Reset values:
  - state = HDR0, `rx_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_run`=0, `load_error`=0, `words_loaded`=0.
  - `csum`=0, byte counter = 0.
- Reset mid-operation returns everything to the reset values and discards any partial word. Instruction-memory contents are not cleared; they are overwritten by the next load.

## Timing
- `rx_ready` is a registered function of state. A stall in `rx_valid` of any length is tolerated, and no byte is lost or duplicated.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. They are valid together for exactly one cycle, the cycle after the edge that accepted the word's 4th byte.
- `words_loaded` increments on the same edge that raises `imem_we`.
- Back-to-back words (a byte every cycle) produce one `imem_we` pulse every 4 cycles.
- `cpu_run` rises on the edge that accepts a matching CHK byte, so it is visible in the next cycle.
- `load_error` rises on the edge that accepts a mismatching CHK byte, or on the edge that accepts an oversize HDR1 byte.
- The final write's `imem_we` pulse completes no later than the cycle `cpu_run` rises, because CHK is accepted at the earliest one cycle after the last payload byte.
- `cpu_run` and `load_error` are never 1 simultaneously.

## Test plan
- Good image: ADDR_WIDTH=10, bytes 02 00 93 00 50 00 13 01 10 00 C3, one per cycle.
  - Write addr 0 = 0x00500093, then addr 1 = 0x00100113.
  - `words_loaded`=2.
  - `cpu_run`=1 the cycle after C3 is accepted; `rx_ready`=0 thereafter.
- Bad checksum: same stream with last byte C2.
  - Both writes still occur.
  - `load_error`=1 after C2; `cpu_run` stays 0; `rx_ready`=0.
- Empty image: 00 00 00.
  - No `imem_we`.
  - `cpu_run`=1 after the third byte; `words_loaded`=0.
- Oversize: header 01 04 (N=1025) with ADDR_WIDTH=10.
  - `load_error`=1 the cycle after byte 04.
  - No `imem_we`; subsequent `rx_valid` is ignored.
- Backpressure/gaps: the good-image stream with random 0–5 idle cycles between bytes.
  - Identical writes and final state to the first test.
  - Bytes held on `rx_valid` after DONE are never accepted.
- Reset mid-word: drop `reset` to 0 asynchronously after 02 00 93 00.
  - All outputs return to reset values immediately.
  - After releasing `reset`, the full good-image stream loads correctly and `cpu_run`=1.
